// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, opcodes, flag indices and sequencer state encoding
package alu_pkg;
  localparam int ALU_DATA_W = 4;
  localparam int ALU_OP_W = 3;
  localparam logic [ALU_OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 3'b001;
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_NEG = 2;
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} seq_state_t;
endpackage

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: synchronous FIFO; push while full is accepted only together with a pop
module alu_rsp_fifo #(
  parameter int W = 7,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= wdata;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues commands to a combinational ALU and queues its results
module alu_cmd_sequencer import alu_pkg::*; #(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W = ALU_OP_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_opcode,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic              cmd_chain,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_neg,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [2:0]        rsp_flags,
  output logic [7:0]        op_count
);
  seq_state_t state, next;
  logic [DATA_W-1:0] acc_q;
  logic [2:0] flags;
  logic busy, full, empty, push, pop;
  assign flags[FLAG_ZERO] = alu_zero;
  assign flags[FLAG_CARRY] = alu_carry;
  assign flags[FLAG_NEG] = alu_neg;
  assign cmd_ready = state == IDLE && !rst;
  assign busy = state != IDLE;
  assign pop = rsp_valid && rsp_ready;
  // A pop on the same edge frees the slot the capture needs
  assign push = busy && (!full || pop);
  assign rsp_valid = !empty;
  always_comb begin
    next = state;
    next = (state == IDLE) ? (cmd_valid ? EXEC : IDLE) : (push ? IDLE : HOLD);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      alu_a <= '0;
      alu_b <= '0;
      alu_opcode <= '0;
      acc_q <= '0;
      op_count <= '0;
    end else begin
      state <= next;
      if (cmd_ready && cmd_valid) begin
        alu_a <= cmd_chain ? acc_q : cmd_a;
        alu_b <= cmd_b;
        alu_opcode <= cmd_opcode;
      end
      if (push) begin
        acc_q <= alu_result;
        op_count <= op_count + 8'd1;
      end
    end
  end
  alu_rsp_fifo #(.W(DATA_W + 3), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .wdata({alu_result, flags}),
    .rdata({rsp_result, rsp_flags}),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed vectors with a response scoreboard and a behavioural ALU
module tb_alu_cmd_sequencer;
  logic clk = 0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_chain, rsp_valid, rsp_ready;
  logic [2:0] cmd_opcode, alu_opcode, rsp_flags;
  logic [3:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, rsp_result;
  logic alu_zero, alu_carry, alu_neg;
  logic [7:0] op_count;
  logic [4:0] add_r;
  logic [6:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  alu_cmd_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_neg(alu_neg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .op_count(op_count)
  );
  // ALU: add/sub with carry as carry-out/borrow, xor for other opcodes
  always_comb begin
    add_r = {1'b0, alu_a} + {1'b0, alu_b};
    alu_result = (alu_opcode == 3'b000) ? add_r[3:0] : (alu_opcode == 3'b001) ? alu_a - alu_b : alu_a ^ alu_b;
    alu_carry = (alu_opcode == 3'b000) ? add_r[4] : (alu_opcode == 3'b001) ? (alu_a < alu_b) : 1'b0;
    alu_neg = alu_result[3];
    alu_zero = alu_result == 4'd0;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("unexpected_rsp", {rsp_result, rsp_flags}, 32'h7f);
      else check("rsp", {rsp_result, rsp_flags}, exp_q.pop_front());
    end
  end
  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic ch, input bit want, input logic [6:0] exp);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 1);
    cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_chain = ch; cmd_valid = 1;
    if (want) exp_q.push_back(exp);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask
  initial begin
    rst = 1; cmd_valid = 0; cmd_opcode = 0; cmd_a = 0; cmd_b = 0; cmd_chain = 0; rsp_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    check("rst_alu", {alu_a, alu_b, alu_opcode}, 0);
    check("rst_rsp", {rsp_result, rsp_flags, op_count}, 0);
    rst = 0;
    // add with carry, then latency and single-cycle rsp_valid
    issue(3'b000, 4'd15, 4'd5, 0, 1, {4'd4, 3'b010});
    check("t1_alu", {alu_a, alu_b, alu_opcode}, {4'd15, 4'd5, 3'b000});
    check("t1_valid_early", {31'd0, rsp_valid}, 0);
    @(posedge clk); #1;
    check("t1_valid", {31'd0, rsp_valid}, 1);
    check("t1_op_count", op_count, 1);
    drain();
    issue(3'b000, 4'd10, 4'd3, 0, 1, {4'd13, 3'b100});
    @(posedge clk); #1;
    check("t2_valid_on", {31'd0, rsp_valid}, 1);
    @(posedge clk); #1;
    check("t2_valid_off", {31'd0, rsp_valid}, 0);
    issue(3'b001, 4'd11, 4'd7, 0, 1, {4'd4, 3'b000});
    issue(3'b001, 4'd7, 4'd10, 0, 1, {4'd13, 3'b110});
    issue(3'b001, 4'd12, 4'd4, 0, 1, {4'd8, 3'b100});
    drain();
    // chained accumulate: 3+4, then acc+9
    issue(3'b000, 4'd3, 4'd4, 0, 1, {4'd7, 3'b000});
    issue(3'b000, 4'd0, 4'd9, 1, 1, {4'd0, 3'b011});
    check("chain_alu_a", alu_a, 7);
    drain();
    check("op_count_7", op_count, 7);
    // backpressure: two fill the FIFO, third waits in HOLD
    rsp_ready = 0;
    issue(3'b001, 4'd5, 4'd1, 0, 1, {4'd4, 3'b000});
    issue(3'b000, 4'd8, 4'd8, 0, 1, {4'd0, 3'b011});
    issue(3'b010, 4'd9, 4'd3, 0, 1, {4'd10, 3'b100});
    @(posedge clk); #1;
    check("hold_cmd_ready", {31'd0, cmd_ready}, 0);
    check("hold_alu", {alu_a, alu_b, alu_opcode}, {4'd9, 4'd3, 3'b010});
    repeat (3) @(posedge clk);
    #1;
    check("hold_stable", {alu_a, alu_b, alu_opcode}, {4'd9, 4'd3, 3'b010});
    check("hold_op_count", op_count, 9);
    check("hold_head", {rsp_result, rsp_flags}, {4'd4, 3'b000});
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    check("popush_op_count", op_count, 10);
    check("popush_cmd_ready", {31'd0, cmd_ready}, 1);
    check("popush_valid", {31'd0, rsp_valid}, 1);
    rsp_ready = 1;
    drain();
    // reset during EXEC aborts the operation
    issue(3'b000, 4'd1, 4'd1, 0, 0, 7'd0);
    #2 rst = 1;
    #1;
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 0);
    check("mid_rst_out", {alu_a, alu_b, alu_opcode, rsp_valid, rsp_result, rsp_flags, op_count}, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    check("post_rst", {rsp_valid, op_count}, 0);
    issue(3'b000, 4'd2, 4'd3, 0, 1, {4'd5, 3'b000});
    drain();
    check("post_rst_op_count", op_count, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
